mgmt_gpio_in_capture: RTL and testbench
=======================================

Name: mgmt_gpio_in_capture

Overview:
- Receive-side companion to the management GPIO buffer row.
- Takes the 18 buffered `mgmt_gpio_in` lines from the pad ring and synchronises them into the management clock domain.
- Detects per-pin rising and falling edges and holds them as sticky, write-1-to-clear event flags.
- Drives one combined interrupt to the housekeeping block. A simple synchronous register port is used for configuration and readback.

Parameters:
- NPINS, 18, number of management GPIO input lines captured.
- SYNC_STAGES, 2, synchroniser flop depth (legal values 2..3).
- DB_PRESCALE, 16, debounce sample-tick period in clocks (optional feature only, >=2).
- DB_COUNT, 3, consecutive equal debounce samples required to accept a new level (1..7).

Ports:
- wb_clk_i  input  1  management clock.
- wb_rst_i  input  1  asynchronous, active-high reset.
- gpio_in_buf  input  NPINS  buffered pad inputs; asynchronous to wb_clk_i.
- reg_we  input  1  register write strobe, single cycle.
- reg_addr  input  2  register select: 0=LEVEL(ro), 1=RISE_EN, 2=FALL_EN, 3=STATUS(w1c).
- reg_wdata  input  NPINS  write data.
- reg_rdata  output  NPINS  read data, registered; valid 1 cycle after reg_addr is presented.
- gpio_level  output  NPINS  synchronised (and, if enabled, debounced) pin levels.
- gpio_irq  output  1  OR of (STATUS & (RISE_EN | FALL_EN)), registered.

Behaviour:
- Reset (async assert, sync release is by the system reset tree):
  - All synchroniser flops, gpio_level, RISE_EN, FALL_EN, STATUS, reg_rdata and gpio_irq go to 0.
  - The previous-level register also clears to 0. A pin held high through reset therefore produces one rising event after release, if enabled.
- Synchroniser: SYNC_STAGES flops per pin, with no reset-less flops. gpio_level updates SYNC_STAGES cycles after a stable input change (DB off).
- Edge detect: prev <= gpio_level every cycle.
  - rise[i] = gpio_level[i] & ~prev[i]
  - fall[i] = ~gpio_level[i] & prev[i]
- Event set: STATUS[i] sets on (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
  - Edges on disabled pins never set STATUS.
  - Enabling a pin does not retroactively set STATUS.
- STATUS clear: a write to addr 3 clears bits where reg_wdata=1.
  - Simultaneous set and clear on the same bit in the same cycle: set wins, so the bit stays 1 and no event is lost.
- RISE_EN and FALL_EN are plain read/write registers. A write takes effect on the next cycle's edge evaluation.
- Both RISE_EN and FALL_EN set: any transition sets STATUS.
- gpio_irq is updated one cycle after STATUS changes. It deasserts one cycle after the last pending enabled bit clears.
  - Clearing an enable bit masks a pending STATUS bit from gpio_irq but does not clear it.
- Reads:
  - reg_rdata <= selected register each cycle, regardless of reg_we.
  - Reads have no side effects.
  - Writes to addr 0 are ignored.
- Width: reg_wdata/reg_rdata are exactly NPINS wide; there are no unused upper bits.

Optional Feature:
- Macro: MGMT_GPIO_IN_DEBOUNCE_EN.
- Defined:
  - A free-running prescaler produces a 1-cycle tick every DB_PRESCALE clocks. It is reset to 0 and wraps from DB_PRESCALE-1 to 0.
  - Each pin has a 3-bit stability counter. On a tick, if sync_out != gpio_level the counter increments, otherwise it clears.
  - When the counter reaches DB_COUNT, gpio_level takes sync_out and the counter clears.
  - Glitches shorter than DB_COUNT ticks are rejected. Worst-case acceptance latency is SYNC_STAGES + DB_PRESCALE*(DB_COUNT+1) clocks.
  - Counters reset to 0.
- Undefined: no prescaler or counters are built; gpio_level is the synchroniser output directly. The DB_* parameters are ignored.

Test Plan:
1. Reset-release with gpio_in_buf=18'h00001 and RISE_EN written 18'h00001 before the pin rises -> STATUS=18'h00001 and gpio_irq=1 within SYNC_STAGES+2 clocks.
2. RISE_EN=18'h00004, FALL_EN=0; pulse pin 2 high for 10 clocks -> STATUS=18'h00004 only, with no set on the falling edge. Writing 18'h00004 to addr 3 gives STATUS=0 and gpio_irq=0 one cycle later.
3. FALL_EN=18'h20000; drive pin 17 falling in the same cycle as a w1c write of bit 17 -> STATUS[17] stays 1 and gpio_irq stays 1.
4. Set STATUS[5] with RISE_EN[5]=1, then write RISE_EN=0 -> gpio_irq drops. Readback of addr 3 = 18'h00020. Re-enable -> gpio_irq reasserts.
5. Write addr 0 with 18'h3FFFF -> LEVEL readback is unchanged. Drive gpio_in_buf=18'h2AAAA -> addr 0 reads 18'h2AAAA after synchroniser latency.
6. With MGMT_GPIO_IN_DEBOUNCE_EN (DB_PRESCALE=16, DB_COUNT=3):
   - A pin-0 glitch of 20 clocks -> no gpio_level change and no STATUS.
   - A pin-0 level held for 80 clocks -> gpio_level[0]=1 within 2+64 clocks and STATUS[0]=1 if enabled.

Source files
------------

// File: rtl/mgmt_gpio_in_capture.sv
// -----------------------------------------------------------------------------
// mgmt_gpio_in_capture
//
// Receive-side companion to the management GPIO buffer row. The buffered pad
// inputs are brought into the management clock domain and made available as
// gpio_level. Per-pin rising and falling edges are detected, and enabled edges
// are latched into sticky, write-1-to-clear STATUS flags. The enabled pending
// flags are combined into a single registered interrupt.
//
// Optional feature macro: MGMT_GPIO_IN_DEBOUNCE_EN
//   defined   : a shared prescaler tick and per-pin stability counters filter
//               the synchronised levels before edge detection.
//   undefined : gpio_level is the synchroniser output directly, and the DB_*
//               parameters have no effect.
//
// Ports
//   wb_clk_i     in   1      management clock
//   wb_rst_i     in   1      asynchronous active-high reset
//   gpio_in_buf  in   NPINS  buffered pad inputs (asynchronous to wb_clk_i)
//   reg_we       in   1      register write strobe, single cycle
//   reg_addr     in   2      0=LEVEL(ro) 1=RISE_EN 2=FALL_EN 3=STATUS(w1c)
//   reg_wdata    in   NPINS  write data
//   reg_rdata    out  NPINS  registered read data, one cycle after reg_addr
//   gpio_level   out  NPINS  synchronised (optionally debounced) pin levels
//   gpio_irq     out  1      registered OR of STATUS & (RISE_EN | FALL_EN)
// -----------------------------------------------------------------------------
module mgmt_gpio_in_capture #(
  parameter int NPINS       = 18,
  parameter int SYNC_STAGES = 2,
  parameter int DB_PRESCALE = 16,
  parameter int DB_COUNT    = 3
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [NPINS-1:0] gpio_in_buf,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [NPINS-1:0] reg_wdata,
  output logic [NPINS-1:0] reg_rdata,
  output logic [NPINS-1:0] gpio_level,
  output logic             gpio_irq
);

  // Depth is clamped to the supported 2..3 range.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 :
                          ((SYNC_STAGES > 3) ? 3 : SYNC_STAGES);

  localparam bit CFG_OK = (SYNC_STAGES >= 2) && (SYNC_STAGES <= 3) &&
                          (DB_PRESCALE >= 2) &&
                          (DB_COUNT >= 1) && (DB_COUNT <= 7);

  // An unsupported parameter set leaves this named scope in the hierarchy,
  // so it shows up when the elaborated design is inspected.
  if (!CFG_OK) begin : g_cfg_unsupported
  end

  localparam logic [1:0] ADDR_LEVEL  = 2'd0;
  localparam logic [1:0] ADDR_RISE   = 2'd1;
  localparam logic [1:0] ADDR_FALL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // ---- stage p0..pN: metastability synchroniser ----
  logic [NPINS-1:0] sync_p [SYNC_N];
  logic [NPINS-1:0] sync_out;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int s = 0; s < SYNC_N; s++) sync_p[s] <= '0;
    end else begin
      sync_p[0] <= gpio_in_buf;
      for (int s = 1; s < SYNC_N; s++) sync_p[s] <= sync_p[s-1];
    end
  end

  assign sync_out = sync_p[SYNC_N-1];

`ifdef MGMT_GPIO_IN_DEBOUNCE_EN
  // ---- debounce filter ----
  localparam int DB_PRE_N = (DB_PRESCALE < 2) ? 2 : DB_PRESCALE;
  localparam int DB_CNT_N = (DB_COUNT < 1) ? 1 : ((DB_COUNT > 7) ? 7 : DB_COUNT);
  localparam int PW       = $clog2(DB_PRE_N);
  localparam logic [PW-1:0] PRE_LAST = PW'(DB_PRE_N - 1);
  localparam logic [2:0]    CNT_HIT  = 3'(DB_CNT_N);

  logic [PW-1:0]    pre_cnt;
  logic             db_tick;
  logic [2:0]       stab_cnt [NPINS];
  logic [NPINS-1:0] level_q;

  assign db_tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pre_cnt <= '0;
    end else if (db_tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // A pin's counter only advances on ticks where the synchronised input
  // disagrees with the accepted level; any agreeing tick restarts it, so a
  // glitch must persist for DB_COUNT consecutive ticks to be accepted.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      level_q <= '0;
      for (int i = 0; i < NPINS; i++) stab_cnt[i] <= 3'd0;
    end else if (db_tick) begin
      for (int i = 0; i < NPINS; i++) begin
        if (sync_out[i] != level_q[i]) begin
          if ((stab_cnt[i] + 3'd1) == CNT_HIT) begin
            level_q[i]  <= sync_out[i];
            stab_cnt[i] <= 3'd0;
          end else begin
            stab_cnt[i] <= stab_cnt[i] + 3'd1;
          end
        end else begin
          stab_cnt[i] <= 3'd0;
        end
      end
    end
  end

  assign gpio_level = level_q;
`else
  assign gpio_level = sync_out;
`endif

  // ---- edge detect and event capture ----
  logic [NPINS-1:0] prev_level;
  logic [NPINS-1:0] rise_en;
  logic [NPINS-1:0] fall_en;
  logic [NPINS-1:0] status;
  logic [NPINS-1:0] rise;
  logic [NPINS-1:0] fall;
  logic [NPINS-1:0] ev_set;
  logic [NPINS-1:0] ev_clr;
  logic             wr_rise;
  logic             wr_fall;
  logic             wr_status;

  assign rise      = gpio_level & ~prev_level;
  assign fall      = ~gpio_level & prev_level;
  assign ev_set    = (rise & rise_en) | (fall & fall_en);
  assign wr_rise   = reg_we && (reg_addr == ADDR_RISE);
  assign wr_fall   = reg_we && (reg_addr == ADDR_FALL);
  assign wr_status = reg_we && (reg_addr == ADDR_STATUS);
  assign ev_clr    = wr_status ? reg_wdata : '0;

  // The previous level clears on reset, so a pin held high through reset is
  // reported as one rising edge once its level propagates.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      prev_level <= '0;
      rise_en    <= '0;
      fall_en    <= '0;
      status     <= '0;
    end else begin
      prev_level <= gpio_level;
      if (wr_rise) rise_en <= reg_wdata;
      if (wr_fall) fall_en <= reg_wdata;
      // Set is applied after clear so a coincident event is never lost.
      status <= (status & ~ev_clr) | ev_set;
    end
  end

  // ---- output registers: interrupt and read data ----
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      gpio_irq  <= 1'b0;
      reg_rdata <= '0;
    end else begin
      // Masking by the enables only hides a pending bit; STATUS keeps it.
      gpio_irq <= |(status & (rise_en | fall_en));
      case (reg_addr)
        ADDR_LEVEL:  reg_rdata <= gpio_level;
        ADDR_RISE:   reg_rdata <= rise_en;
        ADDR_FALL:   reg_rdata <= fall_en;
        ADDR_STATUS: reg_rdata <= status;
        default:     reg_rdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mgmt_gpio_in_capture.sv
// -----------------------------------------------------------------------------
// tb_mgmt_gpio_in_capture
//
// Self-checking bench for mgmt_gpio_in_capture. Register reads push the
// expected value into a queue when the address is driven and pop/compare it
// when reg_rdata is produced one cycle later. Level and interrupt outputs are
// compared directly through the same checking task.
// -----------------------------------------------------------------------------
module tb_mgmt_gpio_in_capture;

  localparam int NPINS = 18;
  localparam int SYNC  = 2;
`ifdef MGMT_GPIO_IN_DEBOUNCE_EN
  localparam int SETTLE    = SYNC + 16 * 4 + 4;
  localparam int PULSE     = 80;
  localparam int IRQ_BOUND = SYNC + 16 * 4 + 4;
`else
  localparam int SETTLE    = SYNC + 3;
  localparam int PULSE     = 10;
  localparam int IRQ_BOUND = SYNC + 2;
`endif

  logic             clk;
  logic             rst;
  logic [NPINS-1:0] gpio_in_buf;
  logic             reg_we;
  logic [1:0]       reg_addr;
  logic [NPINS-1:0] reg_wdata;
  logic [NPINS-1:0] reg_rdata;
  logic [NPINS-1:0] gpio_level;
  logic             gpio_irq;

  int checks = 0;
  int errors = 0;
  logic [NPINS-1:0] exp_q [$];

  mgmt_gpio_in_capture #(
    .NPINS      (NPINS),
    .SYNC_STAGES(SYNC),
    .DB_PRESCALE(16),
    .DB_COUNT   (3)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .gpio_in_buf(gpio_in_buf),
    .reg_we     (reg_we),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .gpio_level (gpio_level),
    .gpio_irq   (gpio_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [NPINS-1:0] d);
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    cyc(1);
    reg_we    = 1'b0;
    reg_wdata = '0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [NPINS-1:0] e);
    logic [NPINS-1:0] want;
    reg_addr = a;
    exp_q.push_back(e);
    cyc(1);
    want = exp_q.pop_front();
    check(tag, 32'(reg_rdata), 32'(want));
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    logic seen;
    logic [NPINS-1:0] v;

    rst         = 1'b1;
    gpio_in_buf = 18'h00001;
    reg_we      = 1'b0;
    reg_addr    = 2'd0;
    reg_wdata   = '0;
    cyc(3);
    check("rst_rdata", 32'(reg_rdata), 32'h0);
    check("rst_irq",   32'(gpio_irq),  32'h0);
    check("rst_level", 32'(gpio_level), 32'h0);

    // Pin 0 held high through reset -> one rising event after release.
    rst = 1'b0;
    wr(2'd1, 18'h00001);
    n = 1;
    while (!gpio_irq && n < IRQ_BOUND + 5) begin
      cyc(1);
      n++;
    end
    check("t1_irq",         32'(gpio_irq), 32'h1);
    check("t1_irq_latency", 32'(n <= IRQ_BOUND), 32'h1);
    rd("t1_status", 2'd3, 18'h00001);
    wr(2'd3, 18'h00001);
    check("t1_irq_hold", 32'(gpio_irq), 32'h1);
    cyc(1);
    check("t1_irq_clr", 32'(gpio_irq), 32'h0);
    rd("t1_status_clr", 2'd3, 18'h00000);
    wr(2'd1, 18'h00000);

    // Pin 2 pulse with rise-only enable: falling edge must not set.
    wr(2'd1, 18'h00004);
    wr(2'd2, 18'h00000);
    gpio_in_buf[2] = 1'b1;
    cyc(PULSE);
    gpio_in_buf[2] = 1'b0;
    cyc(SETTLE + 2);
    rd("t2_status", 2'd3, 18'h00004);
    check("t2_irq", 32'(gpio_irq), 32'h1);
    wr(2'd3, 18'h00004);
    cyc(1);
    check("t2_irq_clr", 32'(gpio_irq), 32'h0);
    rd("t2_status_clr", 2'd3, 18'h00000);
    wr(2'd1, 18'h00000);

    // Pin 17 falling edge coincident with a w1c of bit 17: set wins.
    wr(2'd1, 18'h20000);
    wr(2'd2, 18'h20000);
    gpio_in_buf[17] = 1'b1;
    cyc(SETTLE);
    rd("t3_status_rise", 2'd3, 18'h20000);
    wr(2'd1, 18'h00000);
    gpio_in_buf[17] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < SETTLE + 20 && !seen; k++) begin
      cyc(1);
      if (!gpio_level[17]) seen = 1'b1;
    end
    check("t3_fall_seen", 32'(seen), 32'h1);
    // gpio_level just fell; the fall event registers on the next edge.
    wr(2'd3, 18'h20000);
    rd("t3_status_kept", 2'd3, 18'h20000);
    check("t3_irq_kept", 32'(gpio_irq), 32'h1);
    wr(2'd3, 18'h20000);
    wr(2'd2, 18'h00000);
    rd("t3_status_clr", 2'd3, 18'h00000);

    // Masking a pending bit via its enable.
    wr(2'd1, 18'h00020);
    gpio_in_buf[5] = 1'b1;
    cyc(SETTLE);
    check("t4_irq", 32'(gpio_irq), 32'h1);
    wr(2'd1, 18'h00000);
    check("t4_irq_reg_delay", 32'(gpio_irq), 32'h1);
    cyc(1);
    check("t4_irq_masked", 32'(gpio_irq), 32'h0);
    rd("t4_status_pending", 2'd3, 18'h00020);
    wr(2'd1, 18'h00020);
    cyc(1);
    check("t4_irq_reassert", 32'(gpio_irq), 32'h1);
    wr(2'd3, 18'h00020);
    wr(2'd1, 18'h00000);
    cyc(1);
    check("t4_irq_clr", 32'(gpio_irq), 32'h0);

    // LEVEL is read-only and tracks the inputs.
    rd("t5_level", 2'd0, 18'h00021);
    wr(2'd0, 18'h3FFFF);
    rd("t5_level_ro", 2'd0, 18'h00021);
    rd("t5_rise_en", 2'd1, 18'h00000);
    rd("t5_fall_en", 2'd2, 18'h00000);
    gpio_in_buf = 18'h2AAAA;
    cyc(SETTLE);
    rd("t5_level_new", 2'd0, 18'h2AAAA);
    check("t5_level_port", 32'(gpio_level), 32'h2AAAA);
    rd("t5_status_none", 2'd3, 18'h00000);
    check("t5_irq_none", 32'(gpio_irq), 32'h0);

    // Both enables on pin 3; enabling does not set retroactively.
    wr(2'd1, 18'h00008);
    wr(2'd2, 18'h00008);
    cyc(2);
    rd("t7_no_retro", 2'd3, 18'h00000);
    gpio_in_buf = 18'h2AAA2;
    cyc(SETTLE);
    rd("t7_fall_set", 2'd3, 18'h00008);
    wr(2'd3, 18'h00008);
    rd("t7_clr", 2'd3, 18'h00000);
    gpio_in_buf = 18'h2AAAA;
    cyc(SETTLE);
    rd("t7_rise_set", 2'd3, 18'h00008);
    wr(2'd3, 18'h00008);
    wr(2'd1, 18'h00000);
    wr(2'd2, 18'h00000);

    // Enable register read/write round trips with static inputs.
    for (int k = 0; k < 4; k++) begin
      v = NPINS'($urandom);
      wr(2'd1, v);
      rd("t8_rise_rw", 2'd1, v);
      wr(2'd2, ~v);
      rd("t8_fall_rw", 2'd2, ~v);
    end
    wr(2'd1, 18'h00000);
    wr(2'd2, 18'h00000);
    rd("t8_status_quiet", 2'd3, 18'h00000);

`ifdef MGMT_GPIO_IN_DEBOUNCE_EN
    // Debounce: short glitch rejected, held level accepted.
    gpio_in_buf = 18'h00000;
    cyc(SETTLE);
    wr(2'd3, 18'h3FFFF);
    wr(2'd1, 18'h00001);
    gpio_in_buf[0] = 1'b1;
    cyc(20);
    gpio_in_buf[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      cyc(1);
      if (gpio_level[0]) seen = 1'b1;
    end
    check("t6_glitch_level", 32'(seen), 32'h0);
    rd("t6_glitch_status", 2'd3, 18'h00000);
    gpio_in_buf[0] = 1'b1;
    n = 0;
    while (!gpio_level[0] && n < 80) begin
      cyc(1);
      n++;
    end
    check("t6_accept_level",   32'(gpio_level[0]), 32'h1);
    check("t6_accept_latency", 32'(n <= 2 + 64), 32'h1);
    cyc(3);
    rd("t6_accept_status", 2'd3, 18'h00001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
